// File: rtl/score_display_driver.sv
// ---------------------------------------------------------------------------
// score_display_driver
//
// Purpose:
//    Drives NUM_DIGITS seven-segment digits from a VALUE_W-bit binary value,
//    shown either as hex nibbles or as decimal digits. The decimal digits
//    come from a sequential double-dabble engine running one iteration per
//    clock. A timed "GO" / "ERR" overlay can be requested by game control.
//    The overlay is held for MSG_HOLD_MS ticks of the shared millisecond
//    pulse.
//
// Ports:
//    clk           system clock, rising edge
//    rst_n         asynchronous active-low reset
//    disp_mode     1 = hex display, 0 = decimal display
//    one_ms_pulse  single-cycle millisecond tick
//    value         binary value to display
//    msg_req       single-cycle request to show a message
//    msg_sel       message select sampled with msg_req (0 = GO, 1 = ERR)
//    conv_busy     high while the decimal engine is iterating
//    chars_out     registered character codes, digit 0 in the LSBs
//    seg_out       segment patterns, 8 bits per digit, digit 0 in the LSBs
//
// Character codes: 0x00-0x0F hex digits, 0x10 R, 0x11 O, 0x12 G, 0x13 blank.
// Segment format: {dp, g, f, e, d, c, b, a}, active low, dp always off.
//
// Optional build macro:
//    SCORE_DISPLAY_LZB_EN  blank leading zeros in decimal mode (digit 0 is
//                          always shown). Hex mode is unaffected.
// ---------------------------------------------------------------------------

// Character-code to seven-segment decoder, one instance per digit.
module hex_driver (
   input  logic [4:0] char_code,
   output logic [7:0] seg
);

   // Pure lookup; unused codes fall through to blank.
   always_comb begin
      seg = 8'hFF;
      case (char_code)
         5'h00: seg = 8'hC0;
         5'h01: seg = 8'hF9;
         5'h02: seg = 8'hA4;
         5'h03: seg = 8'hB0;
         5'h04: seg = 8'h99;
         5'h05: seg = 8'h92;
         5'h06: seg = 8'h82;
         5'h07: seg = 8'hF8;
         5'h08: seg = 8'h80;
         5'h09: seg = 8'h90;
         5'h0A: seg = 8'h88;
         5'h0B: seg = 8'h83;
         5'h0C: seg = 8'hC6;
         5'h0D: seg = 8'hA1;
         5'h0E: seg = 8'h86;
         5'h0F: seg = 8'h8E;
         5'h10: seg = 8'hAF;
         5'h11: seg = 8'hC0;
         5'h12: seg = 8'hC2;
         default: seg = 8'hFF;
      endcase
   end

endmodule

module score_display_driver #(
   parameter int NUM_DIGITS  = 6,
   parameter int VALUE_W     = 24,
   parameter int MSG_HOLD_MS = 3000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    disp_mode,
   input  logic                    one_ms_pulse,
   input  logic [VALUE_W-1:0]      value,
   input  logic                    msg_req,
   input  logic                    msg_sel,
   output logic                    conv_busy,
   output logic [5*NUM_DIGITS-1:0] chars_out,
   output logic [8*NUM_DIGITS-1:0] seg_out
);

   localparam int BCD_W  = 4 * NUM_DIGITS;
   localparam int ITER_W = $clog2(VALUE_W + 1);
   localparam int TMR_W  = $clog2(MSG_HOLD_MS + 1);

   localparam logic [4:0] CH_E     = 5'h0E;
   localparam logic [4:0] CH_R     = 5'h10;
   localparam logic [4:0] CH_O     = 5'h11;
   localparam logic [4:0] CH_G     = 5'h12;
   localparam logic [4:0] CH_BLANK = 5'h13;

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) begin
         p = p * 64'd10;
      end
      return p;
   endfunction

   // Smallest value that no longer fits in NUM_DIGITS decimal digits.
   localparam logic [63:0]      DEC_LIMIT = pow10(NUM_DIGITS);
   localparam logic [BCD_W-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

   typedef enum logic {
      SHOW_VALUE,
      SHOW_MSG
   } disp_state_t;

   disp_state_t state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic msg_sel_q, msg_sel_d;

   logic [VALUE_W-1:0] src_latch;
   logic [VALUE_W-1:0] bin_sr;
   logic [VALUE_W-1:0] bin_step;
   logic [BCD_W-1:0]   bcd_work;
   logic [BCD_W-1:0]   bcd_adj;
   logic [BCD_W-1:0]   bcd_step;
   logic [BCD_W-1:0]   bcd_result;
   logic [ITER_W-1:0]  iter_cnt;
   logic [63:0]        src_ext;
   logic               src_overflow;
   logic [BCD_W-1:0]   value_ext;
   logic [5*NUM_DIGITS-1:0] chars_d;
`ifdef SCORE_DISPLAY_LZB_EN
   logic lead_zero;
`endif

   // One double-dabble iteration: add 3 to every BCD digit >= 5, then shift
   // the next binary bit in from the top of the source shift register.
   always_comb begin
      bcd_adj = bcd_work;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (bcd_work[4*k +: 4] >= 4'd5) begin
            bcd_adj[4*k +: 4] = bcd_work[4*k +: 4] + 4'd3;
         end
      end
      bcd_step = (bcd_adj << 1) | BCD_W'(bin_sr[VALUE_W-1]);
      bin_step = bin_sr << 1;
   end

   // Overflow is judged on the latched source, so the saturation decision
   // belongs to the same conversion that produced the BCD digits.
   always_comb begin
      src_ext = '0;
      src_ext[VALUE_W-1:0] = src_latch;
      src_overflow = (src_ext >= DEC_LIMIT);
   end

   // Decimal engine. A new conversion only starts while idle, so a value that
   // changes mid-conversion is picked up once the current one finishes. The
   // visible result register is written once, on the last iteration.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_latch  <= '0;
         bin_sr     <= '0;
         bcd_work   <= '0;
         bcd_result <= '0;
         iter_cnt   <= '0;
         conv_busy  <= 1'b0;
      end else if (!conv_busy) begin
         if (value != src_latch) begin
            src_latch <= value;
            bin_sr    <= value;
            bcd_work  <= '0;
            iter_cnt  <= '0;
            conv_busy <= 1'b1;
         end
      end else begin
         bin_sr   <= bin_step;
         bcd_work <= bcd_step;
         iter_cnt <= iter_cnt + ITER_W'(1);
         if (iter_cnt == ITER_W'(VALUE_W - 1)) begin
            conv_busy  <= 1'b0;
            bcd_result <= src_overflow ? ALL_NINES : bcd_step;
         end
      end
   end

   // Display FSM state register, plus the message timer and latched select.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= SHOW_VALUE;
         timer_q   <= '0;
         msg_sel_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         msg_sel_q <= msg_sel_d;
      end
   end

   // Next-state logic. A fresh request always restarts the hold, which is
   // why it is tested ahead of the timeout.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      msg_sel_d = msg_sel_q;
      case (state_q)
         SHOW_VALUE: begin
            if (msg_req) begin
               state_d   = SHOW_MSG;
               timer_d   = '0;
               msg_sel_d = msg_sel;
            end
         end
         SHOW_MSG: begin
            if (msg_req) begin
               timer_d   = '0;
               msg_sel_d = msg_sel;
            end else if (one_ms_pulse) begin
               if (timer_q == TMR_W'(MSG_HOLD_MS - 1)) begin
                  state_d = SHOW_VALUE;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + TMR_W'(1);
               end
            end
         end
         default: begin
            state_d = SHOW_VALUE;
            timer_d = '0;
         end
      endcase
   end

   always_comb begin
      value_ext = '0;
      value_ext[VALUE_W-1:0] = value;
   end

   // Output logic: selects the characters loaded into chars_out next cycle.
   // Messages sit in the most-significant digits; everything else is blank.
   always_comb begin
      chars_d = {NUM_DIGITS{CH_BLANK}};
`ifdef SCORE_DISPLAY_LZB_EN
      lead_zero = 1'b1;
`endif
      if (state_q == SHOW_MSG) begin
         if (msg_sel_q) begin
            chars_d[5*(NUM_DIGITS-1) +: 5] = CH_E;
            chars_d[5*(NUM_DIGITS-2) +: 5] = CH_R;
            chars_d[5*(NUM_DIGITS-3) +: 5] = CH_R;
         end else begin
            chars_d[5*(NUM_DIGITS-1) +: 5] = CH_G;
            chars_d[5*(NUM_DIGITS-2) +: 5] = CH_O;
         end
      end else if (disp_mode) begin
         for (int k = 0; k < NUM_DIGITS; k++) begin
            chars_d[5*k +: 5] = {1'b0, value_ext[4*k +: 4]};
         end
      end else begin
`ifdef SCORE_DISPLAY_LZB_EN
         // Scan from the top; blanking stops at the first non-zero digit.
         for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (lead_zero && (k != 0) && (bcd_result[4*k +: 4] == 4'd0)) begin
               chars_d[5*k +: 5] = CH_BLANK;
            end else begin
               lead_zero = 1'b0;
               chars_d[5*k +: 5] = {1'b0, bcd_result[4*k +: 4]};
            end
         end
`else
         for (int k = 0; k < NUM_DIGITS; k++) begin
            chars_d[5*k +: 5] = {1'b0, bcd_result[4*k +: 4]};
         end
`endif
      end
   end

   // Registered character outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chars_out <= {NUM_DIGITS{CH_BLANK}};
      end else begin
         chars_out <= chars_d;
      end
   end

   for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
      hex_driver u_hex (
         .char_code (chars_out[5*k +: 5]),
         .seg       (seg_out[8*k +: 8])
      );
   end

endmodule

// File: tb/tb_score_display_driver.sv
// ---------------------------------------------------------------------------
// tb_score_display_driver
//
// Purpose:
//    Self-checking bench for score_display_driver (6 digits, 24-bit value,
//    3 ms message hold). Directed steps first, then a randomized phase. Each
//    cycle is compared against a behavioural model that tracks the displayed
//    decimal number as an integer, and conversions as a countdown of cycles.
//    Honours SCORE_DISPLAY_LZB_EN when the design is built with it.
// ---------------------------------------------------------------------------
module tb_score_display_driver;

   localparam int N    = 6;
   localparam int W    = 24;
   localparam int HOLD = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             disp_mode;
   logic             one_ms_pulse;
   logic [W-1:0]     value;
   logic             msg_req;
   logic             msg_sel;
   logic             conv_busy;
   logic [5*N-1:0]   chars_out;
   logic [8*N-1:0]   seg_out;

   int total = 0;
   int bad   = 0;

   // Behavioural model state.
   int m_src;
   int m_busy_left;
   int m_dec;
   int m_pulses_left;
   bit m_in_msg;
   bit m_sel;

   int cur_v;
   bit cur_mode;

   always #5 clk = ~clk;

   score_display_driver #(
      .NUM_DIGITS  (N),
      .VALUE_W     (W),
      .MSG_HOLD_MS (HOLD)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .disp_mode    (disp_mode),
      .one_ms_pulse (one_ms_pulse),
      .value        (value),
      .msg_req      (msg_req),
      .msg_sel      (msg_sel),
      .conv_busy    (conv_busy),
      .chars_out    (chars_out),
      .seg_out      (seg_out)
   );

   function automatic int pow10(input int n);
      int p;
      p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   // Active-low {dp,g,f,e,d,c,b,a} pattern for each character code.
   function automatic logic [7:0] segOf(input logic [4:0] c);
      case (c)
         5'h00: return 8'hC0;
         5'h01: return 8'hF9;
         5'h02: return 8'hA4;
         5'h03: return 8'hB0;
         5'h04: return 8'h99;
         5'h05: return 8'h92;
         5'h06: return 8'h82;
         5'h07: return 8'hF8;
         5'h08: return 8'h80;
         5'h09: return 8'h90;
         5'h0A: return 8'h88;
         5'h0B: return 8'h83;
         5'h0C: return 8'hC6;
         5'h0D: return 8'hA1;
         5'h0E: return 8'h86;
         5'h0F: return 8'h8E;
         5'h10: return 8'hAF;
         5'h11: return 8'hC0;
         5'h12: return 8'hC2;
         default: return 8'hFF;
      endcase
   endfunction

   // Characters the display should load on the next edge, given the model's
   // current state and the inputs presented before that edge.
   function automatic logic [5*N-1:0] modelChars(input int v, input bit mode);
      logic [5*N-1:0] r;
      int d;
      bit lead;
      for (int k = 0; k < N; k++) r[5*k +: 5] = 5'h13;
      lead = 1'b1;
      if (m_in_msg) begin
         if (m_sel) begin
            r[5*(N-1) +: 5] = 5'h0E;
            r[5*(N-2) +: 5] = 5'h10;
            r[5*(N-3) +: 5] = 5'h10;
         end else begin
            r[5*(N-1) +: 5] = 5'h12;
            r[5*(N-2) +: 5] = 5'h11;
         end
      end else if (mode) begin
         for (int k = 0; k < N; k++) r[5*k +: 5] = {1'b0, 4'((v >> (4*k)) & 15)};
      end else begin
         for (int k = N - 1; k >= 0; k--) begin
            d = (m_dec / pow10(k)) % 10;
`ifdef SCORE_DISPLAY_LZB_EN
            if (lead && d == 0 && k != 0) begin
               r[5*k +: 5] = 5'h13;
            end else begin
               lead = 1'b0;
               r[5*k +: 5] = {1'b0, 4'(d)};
            end
`else
            r[5*k +: 5] = {1'b0, 4'(d)};
`endif
         end
      end
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives one cycle of inputs, advances the model across the clock edge
   // and compares every output one time unit after the edge.
   task automatic applyStimulus(input int v, input bit mode, input bit pulse, input bit req, input bit sel);
      logic [5*N-1:0] exp_chars;
      logic [8*N-1:0] exp_seg;
      value        = W'(v);
      disp_mode    = mode;
      one_ms_pulse = pulse;
      msg_req      = req;
      msg_sel      = sel;
      exp_chars    = modelChars(v, mode);
      @(posedge clk);
      if (m_busy_left == 0) begin
         if (v != m_src) begin
            m_src       = v;
            m_busy_left = W;
         end
      end else begin
         m_busy_left--;
         if (m_busy_left == 0) begin
            m_dec = (m_src >= pow10(N)) ? pow10(N) - 1 : m_src;
         end
      end
      if (!m_in_msg) begin
         if (req) begin
            m_in_msg      = 1'b1;
            m_sel         = sel;
            m_pulses_left = HOLD;
         end
      end else if (req) begin
         m_sel         = sel;
         m_pulses_left = HOLD;
      end else if (pulse) begin
         m_pulses_left--;
         if (m_pulses_left == 0) m_in_msg = 1'b0;
      end
      for (int k = 0; k < N; k++) exp_seg[8*k +: 8] = segOf(exp_chars[5*k +: 5]);
      #1;
      checkOutput("chars", 64'(chars_out), 64'(exp_chars));
      checkOutput("busy", 64'(conv_busy), 64'(m_busy_left != 0));
      checkOutput("seg", 64'(seg_out), 64'(exp_seg));
   endtask

   task automatic hold(input int n);
      for (int i = 0; i < n; i++) applyStimulus(cur_v, cur_mode, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int  kind;
      bit  p;
      bit  r;
      bit  s;

      rst_n        = 1'b0;
      disp_mode    = 1'b0;
      one_ms_pulse = 1'b0;
      value        = '0;
      msg_req      = 1'b0;
      msg_sel      = 1'b0;
      cur_v        = 0;
      cur_mode     = 1'b0;
      m_src         = 0;
      m_busy_left   = 0;
      m_dec         = 0;
      m_pulses_left = 0;
      m_in_msg      = 1'b0;
      m_sel         = 1'b0;

      // Reset state while rst_n is held low.
      #12;
      checkOutput("reset_chars", 64'(chars_out), 64'({N{5'h13}}));
      checkOutput("reset_busy", 64'(conv_busy), 64'd0);
      checkOutput("reset_seg", 64'(seg_out), 64'({N{8'hFF}}));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      hold(2);
`ifdef SCORE_DISPLAY_LZB_EN
      checkOutput("post_reset", 64'(chars_out), 64'({5'h13, 5'h13, 5'h13, 5'h13, 5'h13, 5'h00}));
`else
      checkOutput("post_reset", 64'(chars_out), 64'd0);
`endif

      // 123456: result visible exactly 26 cycles after the change.
      cur_v = 123456;
      hold(25);
      checkOutput("dec_busy_done", 64'(conv_busy), 64'd0);
      hold(1);
      checkOutput("dec_123456", 64'(chars_out), 64'({5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6}));
      cur_mode = 1'b1;
      hold(1);
      checkOutput("hex_123456", 64'(chars_out), 64'({5'h00, 5'h01, 5'h0E, 5'h02, 5'h04, 5'h00}));
      cur_mode = 1'b0;
      hold(1);

      // Upper decimal boundary and saturation.
      cur_v = 999999;
      hold(27);
      checkOutput("dec_999999", 64'(chars_out), 64'({N{5'h09}}));
      cur_v = 1000000;
      hold(27);
      checkOutput("sat_1000000", 64'(chars_out), 64'({N{5'h09}}));
      cur_v = 24'hFFFFFF;
      hold(27);
      checkOutput("sat_ffffff", 64'(chars_out), 64'({N{5'h09}}));

      // ERR message, held for three pulses.
      applyStimulus(cur_v, cur_mode, 1'b0, 1'b1, 1'b1);
      hold(1);
      checkOutput("msg_err", 64'(chars_out), 64'({5'h0E, 5'h10, 5'h10, 5'h13, 5'h13, 5'h13}));
      applyStimulus(cur_v, cur_mode, 1'b1, 1'b0, 1'b0);
      hold(2);
      applyStimulus(cur_v, cur_mode, 1'b1, 1'b0, 1'b0);
      hold(2);
      checkOutput("msg_err_held", 64'(chars_out), 64'({5'h0E, 5'h10, 5'h10, 5'h13, 5'h13, 5'h13}));
      applyStimulus(cur_v, cur_mode, 1'b1, 1'b0, 1'b0);
      hold(1);
      checkOutput("msg_err_gone", 64'(chars_out), 64'({N{5'h09}}));

      // GO message restarted by a request on the second pulse.
      applyStimulus(cur_v, cur_mode, 1'b0, 1'b1, 1'b0);
      hold(1);
      checkOutput("msg_go", 64'(chars_out), 64'({5'h12, 5'h11, 5'h13, 5'h13, 5'h13, 5'h13}));
      applyStimulus(cur_v, cur_mode, 1'b1, 1'b0, 1'b0);
      hold(1);
      applyStimulus(cur_v, cur_mode, 1'b1, 1'b1, 1'b0);
      hold(1);
      applyStimulus(cur_v, cur_mode, 1'b1, 1'b0, 1'b0);
      hold(1);
      applyStimulus(cur_v, cur_mode, 1'b1, 1'b0, 1'b0);
      hold(1);
      checkOutput("msg_go_extended", 64'(chars_out), 64'({5'h12, 5'h11, 5'h13, 5'h13, 5'h13, 5'h13}));
      applyStimulus(cur_v, cur_mode, 1'b1, 1'b0, 1'b0);
      hold(1);
      checkOutput("msg_go_gone", 64'(chars_out), 64'({N{5'h09}}));

      // Value changes during a conversion; last value wins.
      cur_v = 5;
      hold(3);
      cur_v = 77;
      hold(3);
      cur_v = 300;
      hold(60);
`ifdef SCORE_DISPLAY_LZB_EN
      checkOutput("last_wins", 64'(chars_out), 64'({5'h13, 5'h13, 5'h13, 5'h03, 5'h00, 5'h00}));
`else
      checkOutput("last_wins", 64'(chars_out), 64'({5'h00, 5'h00, 5'h00, 5'h03, 5'h00, 5'h00}));
`endif

      // Small values, leading-zero handling.
      cur_v = 42;
      hold(30);
`ifdef SCORE_DISPLAY_LZB_EN
      checkOutput("dec_42", 64'(chars_out), 64'({5'h13, 5'h13, 5'h13, 5'h13, 5'h04, 5'h02}));
`else
      checkOutput("dec_42", 64'(chars_out), 64'({5'h00, 5'h00, 5'h00, 5'h00, 5'h04, 5'h02}));
`endif
      cur_v = 0;
      hold(30);
`ifdef SCORE_DISPLAY_LZB_EN
      checkOutput("dec_0", 64'(chars_out), 64'({5'h13, 5'h13, 5'h13, 5'h13, 5'h13, 5'h00}));
`else
      checkOutput("dec_0", 64'(chars_out), 64'd0);
`endif

      // Randomized phase against the model.
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 39) == 0) begin
            kind = int'($urandom_range(0, 3));
            case (kind)
               0: cur_v = int'($urandom_range(0, 999));
               1: cur_v = int'($urandom_range(0, 999999));
               2: cur_v = int'($urandom_range(999990, 1000010));
               default: cur_v = int'($urandom & 32'h00FF_FFFF);
            endcase
         end
         if ($urandom_range(0, 49) == 0) cur_mode = !cur_mode;
         p = ($urandom_range(0, 5) == 0);
         r = ($urandom_range(0, 79) == 0);
         s = $urandom_range(0, 1) == 1;
         applyStimulus(cur_v, cur_mode, p, r, s);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
